// File: rtl/prog_interval_timer.sv
// Programmable interval timer: a free-running prescaler produces base ticks,
// and a loadable down-counter of base ticks produces one-shot or periodic
// timeout pulses. Freezes while enable is low; stop aborts, start retriggers.
module prog_interval_timer #(
  parameter int PRESCALE = 5000000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  output logic             base_tick,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  // Prescaler just wide enough to hold PRESCALE-1; it never counts past that.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PS_W-1:0]  prescale_reg, prescale_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [CNT_W-1:0] load_reg, load_next;
  logic             periodic_reg, periodic_next;
  logic             base_tick_reg, base_tick_next;
  logic             timeout_reg, timeout_next;

  // A start with a zero count is treated as if it never happened.
  logic start_ok;
  assign start_ok = start && (load_val != '0);

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      prescale_reg  <= '0;
      remaining_reg <= '0;
      load_reg      <= '0;
      periodic_reg  <= 1'b0;
      base_tick_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prescale_reg  <= prescale_next;
      remaining_reg <= remaining_next;
      load_reg      <= load_next;
      periodic_reg  <= periodic_next;
      base_tick_reg <= base_tick_next;
      timeout_reg   <= timeout_next;
    end
  end

  // Next-state logic: stop beats start, start beats the interval end.
  // Any cycle with enable high advances time, including the cycle that
  // leaves PAUSE, so every paused cycle costs exactly one cycle of delay.
  always_comb begin
    state_next     = state_reg;
    prescale_next  = prescale_reg;
    remaining_next = remaining_reg;
    load_next      = load_reg;
    periodic_next  = periodic_reg;
    base_tick_next = 1'b0;
    timeout_next   = 1'b0;

    if (stop) begin
      // In IDLE a stop (even alongside start) simply keeps the block idle.
      if (state_reg != IDLE) begin
        state_next     = IDLE;
        prescale_next  = '0;
        remaining_next = '0;
      end
    end else if (start_ok) begin
      load_next      = load_val;
      periodic_next  = periodic;
      prescale_next  = '0;
      remaining_next = load_val;
      state_next     = enable ? RUN : PAUSE;
    end else if (state_reg != IDLE) begin
      if (!enable) begin
        state_next = PAUSE;
      end else begin
        state_next = RUN;
        if (prescale_reg == PS_LAST) begin
          prescale_next  = '0;
          base_tick_next = 1'b1;
          if (remaining_reg == CNT_W'(1)) begin
            timeout_next = 1'b1;
            if (periodic_reg) begin
              remaining_next = load_reg;
            end else begin
              remaining_next = '0;
              state_next     = IDLE;
            end
          end else begin
            remaining_next = remaining_reg - CNT_W'(1);
          end
        end else begin
          prescale_next = prescale_reg + PS_W'(1);
        end
      end
    end
  end

  assign base_tick = base_tick_reg;
  assign timeout   = timeout_reg;
  assign busy      = (state_reg != IDLE);
  assign remaining = remaining_reg;

endmodule

// File: tb/tb_prog_interval_timer.sv
// Self-checking bench for prog_interval_timer (PRESCALE=4, CNT_W=4):
// hand-derived vector tables, async-reset sequences, and randomized
// stimulus compared against an elapsed-time reference model.
module tb_prog_interval_timer;

  localparam int P = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         periodic = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         base_tick;
  logic         timeout;
  logic         busy;
  logic [W-1:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  prog_interval_timer #(.PRESCALE(P), .CNT_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .load_val  (load_val),
    .base_tick (base_tick),
    .timeout   (timeout),
    .busy      (busy),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The model counts enabled cycles since the interval began; ticks fall on
  // multiples of P and the interval ends after N*P enabled cycles.
  bit m_active;
  bit m_per;
  int m_n;
  int m_el;
  bit m_bt;
  bit m_to;

  function automatic int m_rem();
    return m_active ? (m_n - m_el / P) : 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_per = 0; m_n = 0; m_el = 0; m_bt = 0; m_to = 0;
  endtask

  task automatic model_step();
    m_bt = 0;
    m_to = 0;
    if (stop && m_active) begin
      m_active = 0;
      m_el = 0;
    end else if (!stop && start && load_val != 0) begin
      m_active = 1;
      m_n = int'(load_val);
      m_per = periodic;
      m_el = 0;
    end else if (m_active && enable) begin
      m_el++;
      if (m_el % P == 0) begin
        m_bt = 1;
        if (m_el / P == m_n) begin
          m_to = 1;
          if (m_per) m_el = 0;
          else m_active = 0;
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // return just after the rising edge that samples them.
  task automatic drive(input logic en, input logic st, input logic sp,
                       input logic per, input logic [W-1:0] lv);
    @(negedge clk);
    rst = 1'b1;
    enable = en; start = st; stop = sp; periodic = per; load_val = lv;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".base_tick"}, 32'(base_tick), 32'(m_bt));
    check({tag, ".timeout"},   32'(timeout),   32'(m_to));
    check({tag, ".busy"},      32'(busy),      32'(m_active));
    check({tag, ".remaining"}, 32'(remaining), 32'(m_rem()));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic en, st, sp, per;
    logic [W-1:0] lv;
    int reps;
    logic bt, to, bz;
    logic [W-1:0] rem;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int en, input int st, input int sp, input int per, input int lv,
                     input int reps, input int bt, input int to, input int bz, input int rem);
    vec_t v;
    v.en = en[0]; v.st = st[0]; v.sp = sp[0]; v.per = per[0]; v.lv = W'(lv);
    v.reps = reps; v.bt = bt[0]; v.to = to[0]; v.bz = bz[0]; v.rem = W'(rem);
    tbl.push_back(v);
  endtask

  task automatic run_table(input string name);
    int cyc = 0;
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        drive(tbl[i].en, tbl[i].st, tbl[i].sp, tbl[i].per, tbl[i].lv);
        check($sformatf("%s[%0d].base_tick", name, cyc), 32'(base_tick), 32'(tbl[i].bt));
        check($sformatf("%s[%0d].timeout", name, cyc),   32'(timeout),   32'(tbl[i].to));
        check($sformatf("%s[%0d].busy", name, cyc),      32'(busy),      32'(tbl[i].bz));
        check($sformatf("%s[%0d].remaining", name, cyc), 32'(remaining), 32'(tbl[i].rem));
        cyc++;
      end
    end
    $display("scenario %s: %0d cycles applied", name, cyc);
    tbl.delete();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset state while rst is held low.
    #12;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.remaining", 32'(remaining), 32'd0);
    check("reset.base_tick", 32'(base_tick), 32'd0);
    check("reset.timeout", 32'(timeout), 32'd0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // One-shot, load 3: ticks at +4,+8,+12, timeout at +12.
    add(1,1,0,0,3,1, 0,0,1,3);
    add(1,0,0,0,0,3, 0,0,1,3);
    add(1,0,0,0,0,1, 1,0,1,2);
    add(1,0,0,0,0,3, 0,0,1,2);
    add(1,0,0,0,0,1, 1,0,1,1);
    add(1,0,0,0,0,3, 0,0,1,1);
    add(1,0,0,0,0,1, 1,1,0,0);
    add(1,0,0,0,0,2, 0,0,0,0);
    run_table("oneshot");

    // Periodic, load 2 (periodic input dropped after capture): timeouts at
    // +8,+16,+24, stop at +26.
    add(1,1,0,1,2,1, 0,0,1,2);
    for (int k = 0; k < 3; k++) begin
      add(1,0,0,0,9,3, 0,0,1,2);
      add(1,0,0,0,0,1, 1,0,1,1);
      add(1,0,0,0,0,3, 0,0,1,1);
      add(1,0,0,0,0,1, 1,1,1,2);
    end
    add(1,0,0,0,0,1, 0,0,1,2);
    add(1,0,1,0,0,1, 0,0,0,0);
    add(1,0,0,0,0,8, 0,0,0,0);
    run_table("periodic");

    // Pause for 5 cycles from +3: timeout moves from +8 to +13.
    add(1,1,0,0,2,1, 0,0,1,2);
    add(1,0,0,0,0,2, 0,0,1,2);
    add(0,0,0,0,0,5, 0,0,1,2);
    add(1,0,0,0,0,1, 0,0,1,2);
    add(1,0,0,0,0,1, 1,0,1,1);
    add(1,0,0,0,0,3, 0,0,1,1);
    add(1,0,0,0,0,1, 1,1,0,0);
    add(1,0,0,0,0,1, 0,0,0,0);
    run_table("pause");

    // Stop on the final wrap suppresses timeout; zero-load start and
    // start+stop in idle are both ignored.
    add(1,1,0,0,3,1, 0,0,1,3);
    add(1,0,0,0,0,3, 0,0,1,3);
    add(1,0,0,0,0,1, 1,0,1,2);
    add(1,0,0,0,0,3, 0,0,1,2);
    add(1,0,0,0,0,1, 1,0,1,1);
    add(1,0,0,0,0,3, 0,0,1,1);
    add(1,0,1,0,0,1, 0,0,0,0);
    add(1,0,0,0,0,3, 0,0,0,0);
    add(1,1,0,0,0,1, 0,0,0,0);
    add(1,0,0,0,0,2, 0,0,0,0);
    add(1,1,1,0,5,1, 0,0,0,0);
    add(1,0,0,0,0,5, 0,0,0,0);
    run_table("collide");

    // Retrigger with load 1 at +6: single timeout at +10.
    add(1,1,0,0,3,1, 0,0,1,3);
    add(1,0,0,0,0,3, 0,0,1,3);
    add(1,0,0,0,0,1, 1,0,1,2);
    add(1,0,0,0,0,1, 0,0,1,2);
    add(1,1,0,0,1,1, 0,0,1,1);
    add(1,0,0,0,0,3, 0,0,1,1);
    add(1,0,0,0,0,1, 1,1,0,0);
    add(1,0,0,0,0,2, 0,0,0,0);
    run_table("retrigger");

    // Async reset between edges while a base tick is high.
    drive(1, 1, 0, 0, 3);
    repeat (4) drive(1, 0, 0, 0, 0);
    check("areset.pre_tick", 32'(base_tick), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("areset.busy", 32'(busy), 32'd0);
    check("areset.remaining", 32'(remaining), 32'd0);
    check("areset.base_tick", 32'(base_tick), 32'd0);
    check("areset.timeout", 32'(timeout), 32'd0);
    for (int i = 0; i < 14; i++) begin
      drive(1, 0, 0, 0, 0);
      check_model($sformatf("post_reset[%0d]", i));
    end
    $display("scenario areset: done");

    // Start on the first edge after reset release is accepted.
    #2;
    rst = 1'b0;
    model_reset();
    drive(1, 1, 0, 1, 2);
    check("release_start.busy", 32'(busy), 32'd1);
    check("release_start.remaining", 32'(remaining), 32'd2);
    drive(1, 0, 1, 0, 0);
    check_model("release_stop");
    $display("scenario release_start: done");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 700; i++) begin
      logic en, st, sp, per;
      logic [W-1:0] lv;
      if ($urandom_range(0, 249) == 0) begin
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_model($sformatf("rand_areset[%0d]", i));
      end
      en  = ($urandom_range(0, 7) != 0);
      st  = ($urandom_range(0, 19) == 0);
      sp  = ($urandom_range(0, 39) == 0);
      per = $urandom_range(0, 1) == 1;
      lv  = W'($urandom_range(0, 3));
      drive(en, st, sp, per, lv);
      check_model($sformatf("rand[%0d]", i));
    end
    $display("scenario random: 700 cycles applied");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
